hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIGITS, default 8, number of multiplexed display digits (2..8).
REQ-002 SHALL have parameter SLOT_CYC, default 50000, clock cycles per digit slot (>= GUARD_CYC+2).
REQ-003 SHALL have parameter GUARD_CYC, default 500, cycles at the start of each slot with all digits off (anti-ghosting).
REQ-004 Port: clk  input  1  sole clock, all logic on its rising edge.
REQ-005 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-006 Port: in_valid  input  1  upstream offers a new display value.
REQ-007 Port: in_ready  output  1  block can accept a value this cycle.
REQ-008 Port: in_data  input  4*NDIGITS  nibble k = digit k; digit 0 is least significant.
REQ-009 Port: in_blank_lz  input  1  leading-zero blanking request, captured with in_data.
REQ-010 Port: hexval  output  4  nibble of the current digit, feeds the hex-to-segment decoder.
REQ-011 Port: digit_en  output  NDIGITS  one-hot active-high digit strobe, or all zero.
REQ-012 Port: blank  output  1  high whenever the segment outputs must be dark.

Function
REQ-013 SHALL hold two registers: pending (data, blank_lz, full flag) and display (data, blank_lz).
REQ-014 in_ready SHALL equal NOT pending.full; an accept is in_valid AND in_ready; accept sets pending.full at the next edge.
REQ-015 State machine SHALL have states IDLE, GUARD and ON, with a slot counter and a digit index idx (0..NDIGITS-1).
REQ-016 IDLE: digit_en=0, blank=1, hexval=0. On pending.full, copy pending to display, clear pending.full, set idx=0 and go to GUARD.
REQ-017 GUARD SHALL last exactly GUARD_CYC cycles with digit_en=0 and blank=1, then go to ON.
REQ-018 ON SHALL last SLOT_CYC-GUARD_CYC cycles, with hexval=display nibble idx and digit_en=one-hot(idx) unless the digit is blanked.
REQ-019 On leaving ON, idx SHALL increment modulo NDIGITS and the state SHALL go to GUARD.
REQ-020 When idx wraps from NDIGITS-1 to 0 and pending.full=1, the copy to display and clear of pending.full SHALL happen in that same cycle; the new frame starts on the new value.
REQ-021 An accept in the same cycle as the REQ-020 transfer is impossible (in_ready=0); in_ready SHALL rise the cycle after the transfer.
REQ-022 Digit k>0 SHALL be blanked if display.blank_lz=1 and nibbles k..NDIGITS-1 are all zero. Digit 0 is never blanked.
REQ-023 A blanked digit in ON SHALL drive digit_en=0, blank=1 and hexval=its nibble.
REQ-024 Latency: a value accepted while IDLE SHALL have digit 0 lit GUARD_CYC+2 cycles after the accept edge.
REQ-025 A value accepted mid-frame SHALL be displayed from the next frame boundary. The current frame is never torn.
REQ-026 All outputs SHALL be registered. digit_en SHALL never have more than one bit set.

Reset
REQ-027 While reset_n=0 at a clock edge, the block SHALL go to IDLE, clear pending.full and display, and set idx=0 and the slot counter to 0.
REQ-028 Output values during reset: in_ready=1, digit_en=0, blank=1, hexval=0.
REQ-029 Reset mid-frame or with a value pending SHALL discard all held data. There is no return to GUARD or ON until a new accept.

Structure
REQ-030 Package hex_scan_pkg SHALL hold the state enum (IDLE, GUARD, ON) and default parameter constants.
REQ-031 The slot counter and GUARD/ON end-of-phase pulses SHALL be one sub-module, scan_slot_timer (parameters SLOT_CYC and GUARD_CYC, synchronous clear).
REQ-032 Target size: 120-400 lines of RTL. The decoder is instantiated outside this block.

Verification (NDIGITS=4, SLOT_CYC=8, GUARD_CYC=2)
REQ-033 Reset, then accept 16'h1234 with blank_lz=0 -> digit_en sequence 0001,0010,0100,1000 repeating, with hexval 4,3,2,1. Each digit is on 6 cycles and off 2.
REQ-034 Accept 16'h0050 with blank_lz=1 -> digits 0 and 1 lit (hexval 0, 5). Digits 2 and 3 give digit_en=0 and blank=1 in their slots.
REQ-035 Accept 16'h0000 with blank_lz=1 -> only digit 0 is lit, hexval=0.
REQ-036 During a frame of 16'h1234, offer 16'hABCD, then hold in_valid with 16'hFFFF -> in_ready=0 until the wrap. The next frame shows ABCD; FFFF is accepted the cycle after the wrap.
REQ-037 Pull reset_n low for 1 cycle during the ON slot of digit 2 -> next cycle digit_en=0, blank=1, in_ready=1. The block stays in IDLE with no lit digit until the next accept.
REQ-038 All runs: assert $onehot0(digit_en) every cycle, and assert that the digit_en pattern only changes after 2 cycles of all-zero digit_en.

Source files
------------

// File: rtl/hex_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_pkg
//  Description : Shared types and default constants for the multiplexed
//                hexadecimal display scanner (hex_scan_ctrl and its slot
//                timer).
//  Contents    : scan_state_e - scanner phase (IDLE, GUARD, ON)
//                c_*_dflt     - default parameter values
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_scan_pkg;

    // Scanner phase. GUARD is the dark gap at the start of every digit slot;
    // ON is the remainder of the slot, when the digit may be lit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    localparam int c_ndigits_dflt   = 8;
    localparam int c_slot_cyc_dflt  = 50000;
    localparam int c_guard_cyc_dflt = 500;

endpackage : hex_scan_pkg
`default_nettype wire

// File: rtl/scan_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_slot_timer
//  Description : Free-running digit-slot counter. It counts 0..SLOT_CYC-1 and
//                wraps. It flags the last guard cycle and the last cycle of
//                the slot. The owner qualifies each flag with its own phase.
//  Ports       : clk           in   clock, rising edge
//                reset_n       in   synchronous active-low reset
//                i_clr         in   synchronous clear, counter -> 0
//                o_guard_done  out  counter is on the last guard cycle
//                o_slot_done   out  counter is on the last slot cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_slot_timer
    import hex_scan_pkg::*;
#(
    parameter int SLOT_CYC  = c_slot_cyc_dflt,
    parameter int GUARD_CYC = c_guard_cyc_dflt
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    output logic o_guard_done,
    output logic o_slot_done
);

    localparam int              c_cw         = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [c_cw-1:0] c_guard_last = c_cw'(GUARD_CYC - 1);
    localparam logic [c_cw-1:0] c_slot_last  = c_cw'(SLOT_CYC - 1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_slot_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_guard_done = (r_cnt == c_guard_last);
    assign o_slot_done  = (r_cnt == c_slot_last);

endmodule : scan_slot_timer
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_ctrl
//  Description : Time-multiplexed scanner for an NDIGITS hexadecimal display.
//                A one-entry pending buffer takes new values from upstream.
//                The value moves to the display register only when the
//                scanner is idle or at a frame boundary, so a frame is never
//                torn. Each digit slot starts with a dark guard interval
//                (anti-ghosting), followed by the lit interval. Leading zeros
//                can be blanked.
//  Ports       : clk          in   clock, rising edge
//                reset_n      in   synchronous active-low reset
//                in_valid     in   upstream offers in_data/in_blank_lz
//                in_ready     out  pending buffer is empty
//                in_data      in   4*NDIGITS, nibble k = digit k (0 = LSD)
//                in_blank_lz  in   leading-zero blanking for this value
//                hexval       out  nibble of the current digit
//                digit_en     out  one-hot digit strobe, or all zero
//                blank        out  segments must be dark
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NDIGITS   = c_ndigits_dflt,
    parameter int SLOT_CYC  = c_slot_cyc_dflt,
    parameter int GUARD_CYC = c_guard_cyc_dflt
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   in_data,
    input  logic                   in_blank_lz,
    output logic [3:0]             hexval,
    output logic [NDIGITS-1:0]     digit_en,
    output logic                   blank
);

    localparam int                 c_iw       = $clog2(NDIGITS);
    localparam logic [c_iw-1:0]    c_idx_last = c_iw'(NDIGITS - 1);
    localparam logic [NDIGITS-1:0] c_one      = NDIGITS'(1);

    scan_state_e          r_state,     w_state_nxt;
    logic [c_iw-1:0]      r_idx,       w_idx_nxt;
    logic [4*NDIGITS-1:0] r_pend_data, w_pend_data_nxt;
    logic                 r_pend_blz,  w_pend_blz_nxt;
    logic                 r_pend_full, w_pend_full_nxt;
    logic [4*NDIGITS-1:0] r_disp_data, w_disp_data_nxt;
    logic                 r_disp_blz,  w_disp_blz_nxt;
    logic [3:0]           r_hexval,    w_hexval_nxt;
    logic [NDIGITS-1:0]   r_digit_en,  w_digit_en_nxt;
    logic                 r_blank,     w_blank_nxt;

    logic                 w_accept;
    logic                 w_tmr_clr;
    logic                 w_guard_done;
    logic                 w_slot_done;
    logic [3:0]           w_cur_nib;
    logic [NDIGITS-1:0]   w_lz_blank;

    scan_slot_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .GUARD_CYC (GUARD_CYC)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clr        (w_tmr_clr),
        .o_guard_done (w_guard_done),
        .o_slot_done  (w_slot_done)
    );

    // A digit is a leading zero when it and every digit above it are zero.
    // Digit 0 always shows, so a value of zero still reads "0".
    for (genvar k = 0; k < NDIGITS; k++) begin : g_lz
        if (k == 0) begin : g_lsd
            assign w_lz_blank[k] = 1'b0;
        end else begin : g_upper
            assign w_lz_blank[k] = r_disp_blz && (r_disp_data[4*NDIGITS-1:4*k] == '0);
        end
    end

    assign w_accept  = in_valid && !r_pend_full;
    assign w_cur_nib = r_disp_data[{r_idx, 2'b00} +: 4];

    // Next-state and output decode. Outputs are decoded from the current
    // phase and registered, so they trail the phase register by one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_pend_data_nxt = r_pend_data;
        w_pend_blz_nxt  = r_pend_blz;
        w_pend_full_nxt = r_pend_full;
        w_disp_data_nxt = r_disp_data;
        w_disp_blz_nxt  = r_disp_blz;
        w_tmr_clr       = 1'b0;
        w_hexval_nxt    = '0;
        w_digit_en_nxt  = '0;
        w_blank_nxt     = 1'b1;

        // An accept needs an empty buffer and a transfer needs a full one,
        // so the two never happen in the same cycle.
        if (w_accept) begin
            w_pend_data_nxt = in_data;
            w_pend_blz_nxt  = in_blank_lz;
            w_pend_full_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_tmr_clr = 1'b1;
                if (r_pend_full) begin
                    w_disp_data_nxt = r_pend_data;
                    w_disp_blz_nxt  = r_pend_blz;
                    w_pend_full_nxt = 1'b0;
                    w_idx_nxt       = '0;
                    w_state_nxt     = GUARD;
                end
            end
            GUARD: begin
                if (w_guard_done) begin
                    w_state_nxt = ON;
                end
            end
            ON: begin
                w_hexval_nxt = w_cur_nib;
                if (!w_lz_blank[r_idx]) begin
                    w_digit_en_nxt = c_one << r_idx;
                    w_blank_nxt    = 1'b0;
                end
                if (w_slot_done) begin
                    w_state_nxt = GUARD;
                    if (r_idx == c_idx_last) begin
                        // Frame boundary: the only point where the display
                        // register may change while scanning.
                        w_idx_nxt = '0;
                        if (r_pend_full) begin
                            w_disp_data_nxt = r_pend_data;
                            w_disp_blz_nxt  = r_pend_blz;
                            w_pend_full_nxt = 1'b0;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_pend_data <= '0;
            r_pend_blz  <= 1'b0;
            r_pend_full <= 1'b0;
            r_disp_data <= '0;
            r_disp_blz  <= 1'b0;
            r_hexval    <= '0;
            r_digit_en  <= '0;
            r_blank     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_pend_blz  <= w_pend_blz_nxt;
            r_pend_full <= w_pend_full_nxt;
            r_disp_data <= w_disp_data_nxt;
            r_disp_blz  <= w_disp_blz_nxt;
            r_hexval    <= w_hexval_nxt;
            r_digit_en  <= w_digit_en_nxt;
            r_blank     <= w_blank_nxt;
        end
    end

    assign in_ready = ~r_pend_full;
    assign hexval   = r_hexval;
    assign digit_en = r_digit_en;
    assign blank    = r_blank;

endmodule : hex_scan_ctrl
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_scan_ctrl
//  Description : Self-checking bench for hex_scan_ctrl (4 digits, 8-cycle
//                slots, 2-cycle guard). A frame-position reference model
//                predicts every output. Scenario tasks add fixed
//                expectations for known display values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int GC    = 2;
    localparam int LIT   = SC - GC;
    localparam int FRAME = ND * SC;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        in_valid    = 1'b0;
    logic [15:0] in_data     = '0;
    logic        in_blank_lz = 1'b0;
    logic        in_ready;
    logic [3:0]  hexval;
    logic [3:0]  digit_en;
    logic        blank;

    int n_pass  = 0;
    int n_total = 0;

    hex_scan_ctrl #(
        .NDIGITS   (ND),
        .SLOT_CYC  (SC),
        .GUARD_CYC (GC)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_blank_lz (in_blank_lz),
        .hexval      (hexval),
        .digit_en    (digit_en),
        .blank       (blank)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. The display scans from an origin edge. Its position
    // in the frame is (edge - origin) mod FRAME. Slot = position / SC and
    // the digit is lit once offset >= GC. Outputs show the position of the
    // previous edge. New values enter the display at idle or when the
    // position returns to 0.
    // ------------------------------------------------------------------
    int          cyc      = 0;
    int          m_org    = 0;
    bit          m_active = 1'b0;
    bit          m_pfull  = 1'b0;
    bit          m_pblz   = 1'b0;
    bit          m_dblz   = 1'b0;
    logic [15:0] m_pdata  = '0;
    logic [15:0] m_ddata  = '0;
    logic [3:0]  s_de = '0, e_de = '0, s_hex = '0, e_hex = '0;
    logic        s_blank = 1'b1, e_blank = 1'b1;
    bit          s_hexchk = 1'b1, e_hexchk = 1'b1, e_rdy = 1'b1;

    always @(posedge clk) begin : p_model
        bit pre_full;
        int q, slot, off;
        cyc++;
        pre_full = m_pfull;
        e_de = s_de; e_blank = s_blank; e_hex = s_hex; e_hexchk = s_hexchk;
        if (!reset_n) begin
            m_active = 1'b0; m_pfull = 1'b0; m_ddata = '0; m_dblz = 1'b0;
            e_de = '0; e_blank = 1'b1; e_hex = '0; e_hexchk = 1'b1;
        end else begin
            if (m_active && ((cyc - m_org) % FRAME == 0)) begin
                if (pre_full) begin
                    m_ddata = m_pdata; m_dblz = m_pblz; m_pfull = 1'b0;
                end
            end else if (!m_active && pre_full) begin
                m_ddata = m_pdata; m_dblz = m_pblz; m_pfull = 1'b0;
                m_active = 1'b1; m_org = cyc;
            end
            if (in_valid && !pre_full) begin
                m_pdata = in_data; m_pblz = in_blank_lz; m_pfull = 1'b1;
            end
        end
        e_rdy = !m_pfull;
        if (!m_active) begin
            s_de = '0; s_blank = 1'b1; s_hex = '0; s_hexchk = 1'b1;
        end else begin
            q = (cyc - m_org) % FRAME; slot = q / SC; off = q % SC;
            if (off < GC) begin
                s_de = '0; s_blank = 1'b1; s_hex = '0; s_hexchk = 1'b0;
            end else begin
                s_hex = 4'(m_ddata >> (4 * slot));
                s_hexchk = 1'b1;
                if (m_dblz && slot != 0 && (m_ddata >> (4 * slot)) == 16'h0) begin
                    s_de = '0; s_blank = 1'b1;
                end else begin
                    s_de = 4'(1 << slot); s_blank = 1'b0;
                end
            end
        end
    end

    // Strobe invariants: at most one digit on. A lit pattern changes only
    // after at least GC dark cycles.
    logic [3:0] mon_prev  = '0;
    int         mon_zeros = 99;
    int         mon_viol  = 0;
    int         mon_lit   = 0;

    always @(negedge clk) begin
        if (!$onehot0(digit_en)) mon_viol++;
        if (digit_en != 4'b0000) begin
            mon_lit++;
            if (mon_prev == 4'b0000 && mon_zeros < GC) mon_viol++;
            if (mon_prev != 4'b0000 && mon_prev != digit_en) mon_viol++;
            mon_zeros = 0;
        end else begin
            mon_zeros++;
        end
        mon_prev = digit_en;
    end

    // ------------------------------------------------------------------
    // Stimulus drivers
    // ------------------------------------------------------------------
    task automatic apply_reset();
        reset_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Offers one value and returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] d, input logic b);
        bit done = 1'b0;
        in_valid = 1'b1; in_data = d; in_blank_lz = b;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            if (in_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_total++;
        if (!done) $display("FAIL send_accept data=%h in_ready=%b required 1 within bound", d, in_ready);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
        n_total++; if (digit_en !== 4'b0000) $display("FAIL reset_digit_en got=%b want=0000", digit_en); else n_pass++;
        n_total++; if (blank !== 1'b1) $display("FAIL reset_blank got=%b want=1", blank); else n_pass++;
        n_total++; if (hexval !== 4'h0) $display("FAIL reset_hexval got=%h want=0", hexval); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_scan_1234();
        logic [3:0] exp_hex [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0] want_de;
        apply_reset();
        send(16'h1234, 1'b0);
        repeat (GC + 1) @(posedge clk);
        #1;
        n_total++; if (digit_en !== 4'b0000) $display("FAIL latency_dark got=%b want=0000", digit_en); else n_pass++;
        @(posedge clk); #1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < ND; k++) begin
                for (int c = 0; c < SC; c++) begin
                    want_de = (c < LIT) ? (4'b0001 << k) : 4'b0000;
                    n_total++;
                    if (digit_en !== want_de || blank !== (c >= LIT) || (c < LIT && hexval !== exp_hex[k]))
                        $display("FAIL scan_1234 f=%0d k=%0d c=%0d got de=%b bl=%b hex=%h want de=%b bl=%b hex=%h",
                                 f, k, c, digit_en, blank, hexval, want_de, c >= LIT, exp_hex[k]);
                    else n_pass++;
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] cd [2] = '{16'h0050, 16'h0000};
        logic [3:0]  cm [2] = '{4'b0011, 4'b0001};
        logic [3:0]  mask, want_de, want_hex;
        logic [15:0] d;
        for (int i = 0; i < 2; i++) begin
            d = cd[i]; mask = cm[i];
            apply_reset();
            send(d, 1'b1);
            repeat (GC + 2) @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                want_de  = mask[k] ? (4'b0001 << k) : 4'b0000;
                want_hex = 4'(d >> (4 * k));
                n_total++;
                if (digit_en !== want_de || blank !== !mask[k] || hexval !== want_hex)
                    $display("FAIL lz_%h k=%0d got de=%b bl=%b hex=%h want de=%b bl=%b hex=%h",
                             d, k, digit_en, blank, hexval, want_de, !mask[k], want_hex);
                else n_pass++;
                repeat (SC) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        int rise_e = -1;
        apply_reset();
        send(16'h1234, 1'b0);
        repeat (GC + 2) @(posedge clk);
        #1;
        for (int e = 1; e <= 2 * FRAME + 8; e++) begin
            @(posedge clk); #1;
            n_total++;
            if ({in_ready, digit_en, blank} !== {e_rdy, e_de, e_blank} || (e_hexchk && hexval !== e_hex))
                $display("FAIL b2b_model e=%0d got rdy=%b de=%b bl=%b hex=%h want rdy=%b de=%b bl=%b hex=%h",
                         e, in_ready, digit_en, blank, hexval, e_rdy, e_de, e_blank, e_hex);
            else n_pass++;
            if (e >= 9 && rise_e < 0 && in_ready === 1'b1) rise_e = e;
            if (e == 16) begin
                n_total++; if (hexval !== 4'h2) $display("FAIL b2b_no_tear_d2 got=%h want=2", hexval); else n_pass++;
            end
            if (e == 24) begin
                n_total++; if (hexval !== 4'h1) $display("FAIL b2b_no_tear_d3 got=%h want=1", hexval); else n_pass++;
            end
            if (e == 30) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL b2b_ffff_taken in_ready=%b want=0", in_ready); else n_pass++;
                in_valid = 1'b0;
            end
            if (e == 32) begin
                n_total++;
                if (digit_en !== 4'b0001 || hexval !== 4'hD) $display("FAIL b2b_abcd_d0 got de=%b hex=%h want de=0001 hex=d", digit_en, hexval);
                else n_pass++;
            end
            if (e == 40) begin
                n_total++; if (hexval !== 4'hC) $display("FAIL b2b_abcd_d1 got=%h want=c", hexval); else n_pass++;
            end
            if (e == 64) begin
                n_total++;
                if (digit_en !== 4'b0001 || hexval !== 4'hF) $display("FAIL b2b_ffff_d0 got de=%b hex=%h want de=0001 hex=f", digit_en, hexval);
                else n_pass++;
            end
            if (e == 8) begin in_valid = 1'b1; in_data = 16'hABCD; in_blank_lz = 1'b0; end
            if (e == 9) in_data = 16'hFFFF;
        end
        n_total++;
        if (rise_e != 29) $display("FAIL b2b_ready_rise got e=%0d want e=29", rise_e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int lit_after = 0;
        apply_reset();
        send(16'h1234, 1'b0);
        repeat (GC + 2) @(posedge clk);
        #1;
        repeat (16) @(posedge clk);
        #1;
        n_total++; if (digit_en !== 4'b0100) $display("FAIL rst_mid_pre got de=%b want=0100", digit_en); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_total++;
        if (digit_en !== 4'b0000 || blank !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL rst_mid_post got de=%b bl=%b rdy=%b want de=0000 bl=1 rdy=1", digit_en, blank, in_ready);
        else n_pass++;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(posedge clk); #1;
            if (digit_en !== 4'b0000 || blank !== 1'b1) lit_after++;
            n_total++;
            if ({in_ready, digit_en, blank} !== {e_rdy, e_de, e_blank} || (e_hexchk && hexval !== e_hex))
                $display("FAIL rst_mid_model c=%0d got rdy=%b de=%b bl=%b hex=%h want rdy=%b de=%b bl=%b hex=%h",
                         c, in_ready, digit_en, blank, hexval, e_rdy, e_de, e_blank, e_hex);
            else n_pass++;
        end
        n_total++;
        if (lit_after != 0) $display("FAIL rst_mid_stays_idle lit_cycles=%0d want=0", lit_after);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int c = 0; c < 40 * FRAME; c++) begin
            @(posedge clk); #1;
            n_total++;
            if ({in_ready, digit_en, blank} !== {e_rdy, e_de, e_blank} || (e_hexchk && hexval !== e_hex))
                $display("FAIL random_model c=%0d got rdy=%b de=%b bl=%b hex=%h want rdy=%b de=%b bl=%b hex=%h",
                         c, in_ready, digit_en, blank, hexval, e_rdy, e_de, e_blank, e_hex);
            else n_pass++;
            d = 16'($urandom);
            d = d >> (4 * $urandom_range(0, 4));
            in_data     = d;
            in_blank_lz = 1'($urandom_range(0, 1));
            in_valid    = ($urandom_range(0, 11) == 0);
            reset_n     = ($urandom_range(0, 299) != 0);
        end
        reset_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_invariants();
        n_total++;
        if (mon_viol != 0) $display("FAIL strobe_invariants violations=%0d want=0", mon_viol);
        else n_pass++;
        n_total++;
        if (mon_lit == 0) $display("FAIL strobe_activity lit_cycles=%0d want>0", mon_lit);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_leading_zero();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_hex_scan_ctrl
`default_nettype wire
